// File: rtl/uart_tx.sv
// UART transmitter: accepts one byte per AXI-Stream handshake and shifts it
// onto txd as start bit, DATA_BITS data bits (LSB first), an optional parity
// bit and STOP_BITS stop bits, each bit held CLKS_PER_BIT clock cycles.
// txd, s_tready and busy are all driven straight from flops.
module uart_tx #(
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1,
  parameter int PARITY       = 0,
  parameter int CLKS_PER_BIT = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] s_tdata,
  input  logic       s_tvalid,
  output logic       s_tready,
  output logic       txd,
  output logic       busy
);

  localparam int TIMER_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int CNT_MAX = (DATA_BITS > STOP_BITS) ? DATA_BITS : STOP_BITS;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [TIMER_W-1:0] TIMER_LAST    = TIMER_W'(CLKS_PER_BIT - 1);
  localparam logic [TIMER_W-1:0] TIMER_PRELAST = TIMER_W'(CLKS_PER_BIT - 2);
  localparam logic [TIMER_W-1:0] TIMER_ONE     = TIMER_W'(1);
  localparam logic [CNT_W-1:0]   DATA_LAST     = CNT_W'(DATA_BITS - 1);
  localparam logic [CNT_W-1:0]   STOP_LAST     = CNT_W'(STOP_BITS - 1);
  localparam logic [CNT_W-1:0]   CNT_ONE       = CNT_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  // Parity bit for the latched data word: even makes the total count of
  // ones (data + parity) even, odd makes it odd.
  function automatic logic parity_bit(input logic [DATA_BITS-1:0] d);
    logic p;
    p = ^d;
    if (PARITY == 1) begin
      parity_bit = ~p;
    end else begin
      parity_bit = p;
    end
  endfunction

  state_t                 state_r,  state_s;
  logic [TIMER_W-1:0]     timer_r,  timer_s;
  logic [CNT_W-1:0]       bitcnt_r, bitcnt_s;
  logic [DATA_BITS-1:0]   shift_r,  shift_s;
  logic                   par_r,    par_s;
  logic                   txd_r,    txd_s;
  logic                   tready_r, tready_s;
  logic                   busy_r,   busy_s;
  logic                   bit_end_s;
  logic                   accept_s;

  assign s_tready = tready_r;
  assign txd      = txd_r;
  assign busy     = busy_r;

  // Next-state and next-output logic for the frame sequencer.
  always_comb begin
    state_s   = state_r;
    bitcnt_s  = bitcnt_r;
    shift_s   = shift_r;
    par_s     = par_r;
    txd_s     = txd_r;
    tready_s  = 1'b0;
    busy_s    = busy_r;
    bit_end_s = (timer_r == TIMER_LAST);
    accept_s  = s_tvalid && tready_r;
    if (bit_end_s) begin
      timer_s = '0;
    end else begin
      timer_s = timer_r + TIMER_ONE;
    end

    case (state_r)
      ST_IDLE: begin
        txd_s    = 1'b1;
        busy_s   = 1'b0;
        tready_s = 1'b1;
        timer_s  = '0;
        if (accept_s) begin
          // Start bit goes out on the very edge that takes the byte.
          shift_s  = s_tdata[DATA_BITS-1:0];
          par_s    = parity_bit(s_tdata[DATA_BITS-1:0]);
          txd_s    = 1'b0;
          busy_s   = 1'b1;
          tready_s = 1'b0;
          state_s  = ST_START;
        end else begin
          state_s  = ST_IDLE;
        end
      end

      ST_START: begin
        if (bit_end_s) begin
          txd_s    = shift_r[0];
          shift_s  = shift_r >> 1;
          bitcnt_s = '0;
          state_s  = ST_DATA;
        end else begin
          txd_s    = 1'b0;
        end
      end

      ST_DATA: begin
        if (bit_end_s) begin
          if (bitcnt_r == DATA_LAST) begin
            bitcnt_s = '0;
            if (PARITY != 0) begin
              txd_s   = par_r;
              state_s = ST_PARITY;
            end else begin
              txd_s   = 1'b1;
              state_s = ST_STOP;
            end
          end else begin
            txd_s    = shift_r[0];
            shift_s  = shift_r >> 1;
            bitcnt_s = bitcnt_r + CNT_ONE;
          end
        end else begin
          state_s = ST_DATA;
        end
      end

      ST_PARITY: begin
        if (bit_end_s) begin
          txd_s    = 1'b1;
          bitcnt_s = '0;
          state_s  = ST_STOP;
        end else begin
          state_s  = ST_PARITY;
        end
      end

      ST_STOP: begin
        txd_s = 1'b1;
        // Open the input one cycle early so a new byte can be taken in the
        // final stop cycle without leaving an idle gap on the line.
        if ((bitcnt_r == STOP_LAST) && (timer_r == TIMER_PRELAST)) begin
          tready_s = 1'b1;
        end else begin
          tready_s = 1'b0;
        end
        if (bit_end_s) begin
          if (bitcnt_r == STOP_LAST) begin
            if (accept_s) begin
              shift_s  = s_tdata[DATA_BITS-1:0];
              par_s    = parity_bit(s_tdata[DATA_BITS-1:0]);
              txd_s    = 1'b0;
              busy_s   = 1'b1;
              tready_s = 1'b0;
              state_s  = ST_START;
            end else begin
              busy_s   = 1'b0;
              tready_s = 1'b1;
              state_s  = ST_IDLE;
            end
          end else begin
            bitcnt_s = bitcnt_r + CNT_ONE;
          end
        end else begin
          state_s = ST_STOP;
        end
      end

      default: begin
        state_s  = ST_IDLE;
        txd_s    = 1'b1;
        busy_s   = 1'b0;
        tready_s = 1'b0;
        timer_s  = '0;
        bitcnt_s = '0;
      end
    endcase
  end

  // State, datapath and output registers; reset parks the line at MARK.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r  <= ST_IDLE;
      timer_r  <= '0;
      bitcnt_r <= '0;
      shift_r  <= '0;
      par_r    <= 1'b0;
      txd_r    <= 1'b1;
      tready_r <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      state_r  <= state_s;
      timer_r  <= timer_s;
      bitcnt_r <= bitcnt_s;
      shift_r  <= shift_s;
      par_r    <= par_s;
      txd_r    <= txd_s;
      tready_r <= tready_s;
      busy_r   <= busy_s;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Testbench for uart_tx: four instances (8N1, 8E1, 8O1, 7N2) driven with
// directed and random bytes; every cycle is compared with a frame model
// built from the bit list of each byte.
module tb_uart_tx;

  localparam int CPB = 8;

  typedef bit bitq_t[$];

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] tdata_v [4];
  logic [3:0] tvalid_v;
  logic [3:0] tready_w;
  logic [3:0] txd_w;
  logic [3:0] busy_w;

  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] pend_q[$];

  function automatic int cfg_db(input int g);
    return (g == 3) ? 7 : 8;
  endfunction

  function automatic int cfg_sb(input int g);
    return (g == 3) ? 2 : 1;
  endfunction

  function automatic int cfg_par(input int g);
    return (g == 1) ? 2 : ((g == 2) ? 1 : 0);
  endfunction

  for (genvar g = 0; g < 4; g++) begin : g_dut
    uart_tx #(
      .DATA_BITS   (cfg_db(g)),
      .STOP_BITS   (cfg_sb(g)),
      .PARITY      (cfg_par(g)),
      .CLKS_PER_BIT(CPB)
    ) u_dut (
      .clk     (clk),
      .reset   (reset),
      .s_tdata (tdata_v[g]),
      .s_tvalid(tvalid_v[g]),
      .s_tready(tready_w[g]),
      .txd     (txd_w[g]),
      .busy    (busy_w[g])
    );
  end

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Line bits of one frame: start, data LSB first, parity, stop bits.
  function automatic bitq_t frame_bits(input int g, input logic [7:0] b);
    bitq_t q;
    int ones;
    ones = 0;
    q.push_back(1'b0);
    for (int i = 0; i < cfg_db(g); i++) begin
      q.push_back(b[i]);
      ones += int'(b[i]);
    end
    if (cfg_par(g) == 2) q.push_back(ones % 2 == 1);
    if (cfg_par(g) == 1) q.push_back(ones % 2 == 0);
    for (int i = 0; i < cfg_sb(g); i++) q.push_back(1'b1);
    return q;
  endfunction

  // Sends pend_q on instance g (entered and left at a negedge), checking
  // txd/busy/s_tready every cycle against the frame model.
  task automatic run(input int g, input bit scramble, input int max_cyc,
                     input bit partial, input string tag);
    bitq_t fb;
    int rem, flen, cyc, k;
    bit hs;
    logic e_txd, e_rdy, e_busy;
    logic [7:0] b;
    rem = 0; flen = 0; cyc = 0; b = 8'h00;
    while ((pend_q.size() > 0 || rem > 0) && cyc < max_cyc) begin
      if (rem == 0) begin
        e_txd = 1'b1; e_busy = 1'b0; e_rdy = 1'b1;
      end else begin
        k = flen - rem;
        e_txd = fb[k / CPB]; e_busy = 1'b1; e_rdy = (k == flen - 1);
      end
      check({tag, ".txd"},   32'(txd_w[g]),    32'(e_txd));
      check({tag, ".busy"},  32'(busy_w[g]),   32'(e_busy));
      check({tag, ".tready"}, 32'(tready_w[g]), 32'(e_rdy));
      hs = e_rdy && (pend_q.size() > 0) && (!scramble || $urandom_range(0, 1) == 1);
      if (hs) begin
        b = pend_q.pop_front();
        tvalid_v[g] = 1'b1;
        tdata_v[g]  = b;
      end else begin
        tvalid_v[g] = (scramble && !e_rdy) ? 1'($urandom_range(0, 1)) : 1'b0;
        tdata_v[g]  = 8'($urandom);
      end
      @(posedge clk);
      if (hs) begin
        fb   = frame_bits(g, b);
        flen = fb.size() * CPB;
        rem  = flen;
      end else if (rem > 0) begin
        rem--;
      end
      @(negedge clk);
      cyc++;
    end
    tvalid_v[g] = 1'b0;
    if (!partial) begin
      check({tag, ".in_time"}, 32'(cyc < max_cyc), 32'd1);
      check({tag, ".idle_txd"}, 32'(txd_w[g]), 32'd1);
      check({tag, ".idle_busy"}, 32'(busy_w[g]), 32'd0);
      check({tag, ".idle_tready"}, 32'(tready_w[g]), 32'd1);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset    = 1'b1;
    tvalid_v = 4'b0000;
    for (int i = 0; i < 4; i++) tdata_v[i] = 8'h00;
    #1;
    for (int g = 0; g < 4; g++) begin
      check("rst.txd", 32'(txd_w[g]), 32'd1);
      check("rst.busy", 32'(busy_w[g]), 32'd0);
      check("rst.tready", 32'(tready_w[g]), 32'd0);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1 check("rel.tready_before_edge", 32'(tready_w), 32'h0);
    @(negedge clk);
    check("rel.tready_after_edge", 32'(tready_w), 32'hF);

    pend_q = '{8'hA5};        run(0, 1'b0, 400, 1'b0, "8n1_a5");
    pend_q = '{8'h00, 8'hFF}; run(0, 1'b0, 400, 1'b0, "b2b");
    pend_q = '{8'h07};        run(1, 1'b0, 400, 1'b0, "even_07");
    pend_q = '{8'h07};        run(2, 1'b0, 400, 1'b0, "odd_07");
    pend_q = '{8'hFF};        run(3, 1'b0, 400, 1'b0, "7n2_ff");
    pend_q = '{8'hFF, 8'h80}; run(3, 1'b0, 400, 1'b0, "7n2_b2b");

    for (int g = 0; g < 4; g++) begin
      for (int i = 0; i < 4; i++) pend_q.push_back(8'($urandom));
      run(g, 1'b0, 1000, 1'b0, "rand");
    end
    for (int i = 0; i < 5; i++) pend_q.push_back(8'($urandom));
    run(0, 1'b0 | 1'b1, 2000, 1'b0, "stall");

    // Abort a frame of 0x00 in the middle of data bit 3.
    pend_q = '{8'h00};
    run(0, 1'b0, 36, 1'b1, "pre_rst");
    pend_q.delete();
    #2 reset = 1'b1;
    #1;
    check("midrst.txd", 32'(txd_w[0]), 32'd1);
    check("midrst.busy", 32'(busy_w[0]), 32'd0);
    check("midrst.tready", 32'(tready_w[0]), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1 check("midrst.tready_held", 32'(tready_w[0]), 32'd0);
    @(negedge clk);
    check("midrst.tready_up", 32'(tready_w[0]), 32'd1);
    pend_q = '{8'h55};
    run(0, 1'b0, 400, 1'b0, "post_rst_55");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
